// File: rtl/brick_field_engine.sv
// Brick field for the breakout graphics path.
// Holds the alive mask and renders live bricks from the pixel scan position.
// Once per frame it walks the field one brick per cycle looking for a ball
// collision, and destroys at most one brick per frame.
//
// state | meaning
// IDLE  | waiting for a frame tick
// SCAN  | testing brick idx against the latched ball box
// DONE  | one-cycle tail after a hit, then back to IDLE
module brick_field_engine #(
  parameter int NUM_COLS   = 8,
  parameter int NUM_ROWS   = 6,
  parameter int BRICK_W    = 35,
  parameter int BRICK_H    = 20,
  parameter int REGION_X_L = 40,
  parameter int REGION_Y_T = 30,
  parameter int BALL_SIZE  = 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [9:0]                                pix_x_i,
  input  logic [9:0]                                pix_y_i,
  input  logic [9:0]                                ball_x_l_i,
  input  logic [9:0]                                ball_y_t_i,
  input  logic                                      refr_tick_i,
  input  logic                                      clear_i,
  output logic                                      brick_on_o,
  output logic                                      busy_o,
  output logic                                      hit_o,
  output logic [1:0]                                hit_side_o,
  output logic [$clog2(NUM_COLS*NUM_ROWS)-1:0]      hit_index_o,
  output logic [$clog2(NUM_COLS*NUM_ROWS+1)-1:0]    bricks_left_o,
  output logic                                      all_cleared_o
);

  localparam int N   = NUM_COLS * NUM_ROWS;
  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);
  localparam int CLW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [10:0] FIELD_X  = 11'(REGION_X_L);
  localparam logic [10:0] FIELD_Y  = 11'(REGION_Y_T);
  localparam logic [10:0] STEP_X   = 11'(BRICK_W);
  localparam logic [10:0] STEP_Y   = 11'(BRICK_H);
  localparam logic [10:0] BRK_W_M1 = 11'(BRICK_W - 1);
  localparam logic [10:0] BRK_H_M1 = 11'(BRICK_H - 1);
  localparam logic [10:0] BRK_W_H  = 11'(BRICK_W / 2);
  localparam logic [10:0] BRK_H_H  = 11'(BRICK_H / 2);
  localparam logic [10:0] BALL_M1  = 11'(BALL_SIZE - 1);
  localparam logic [10:0] BALL_H   = 11'(BALL_SIZE / 2);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [CW-1:0]    left_q, left_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CLW-1:0]   col_q, col_d;
  logic [10:0]      brk_l_q, brk_l_d;
  logic [10:0]      brk_t_q, brk_t_d;
  logic [10:0]      ball_x_q, ball_x_d;
  logic [10:0]      ball_y_q, ball_y_d;
  logic             hit_q, hit_d;
  logic [1:0]       side_q, side_d;
  logic [IW-1:0]    hidx_q, hidx_d;

  logic [10:0]      ball_r, ball_b, brk_r, brk_b;
  logic [10:0]      dx_a, dx_b, dy_a, dy_b, dx, dy;
  logic             overlap;
  logic [1:0]       side_c;

  logic [10:0]      pix_x_w, pix_y_w;

  assign pix_x_w = {1'b0, pix_x_i};
  assign pix_y_w = {1'b0, pix_y_i};

  // Render: a pixel is lit when it falls inside any live brick.
  always_comb begin
    brick_on_o = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (alive_q[j] &&
          (pix_x_w >= 11'(REGION_X_L + (j % NUM_COLS) * BRICK_W)) &&
          (pix_x_w <= 11'(REGION_X_L + (j % NUM_COLS) * BRICK_W + BRICK_W - 1)) &&
          (pix_y_w >= 11'(REGION_Y_T + (j / NUM_COLS) * BRICK_H)) &&
          (pix_y_w <= 11'(REGION_Y_T + (j / NUM_COLS) * BRICK_H + BRICK_H - 1))) begin
        brick_on_o = 1'b1;
      end
    end
  end

  // Collision test of the current brick and classification of the struck face.
  // Penetration depth is only meaningful under overlap, where every difference
  // below is non-negative.
  always_comb begin
    ball_r  = ball_x_q + BALL_M1;
    ball_b  = ball_y_q + BALL_M1;
    brk_r   = brk_l_q + BRK_W_M1;
    brk_b   = brk_t_q + BRK_H_M1;
    overlap = alive_q[idx_q] && (ball_r >= brk_l_q) && (ball_x_q <= brk_r) &&
              (ball_b >= brk_t_q) && (ball_y_q <= brk_b);
    dx_a    = ball_r - brk_l_q;
    dx_b    = brk_r - ball_x_q;
    dy_a    = ball_b - brk_t_q;
    dy_b    = brk_b - ball_y_q;
    dx      = ((dx_a < dx_b) ? dx_a : dx_b) + 11'd1;
    dy      = ((dy_a < dy_b) ? dy_a : dy_b) + 11'd1;
    side_c  = 2'd0;
    if (dx < dy) begin
      side_c = ((ball_x_q + BALL_H) < (brk_l_q + BRK_W_H)) ? 2'd2 : 2'd3;
    end else begin
      side_c = ((ball_y_q + BALL_H) < (brk_t_q + BRK_H_H)) ? 2'd0 : 2'd1;
    end
  end

  // Next-state and datapath updates; clear overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    alive_d  = alive_q;
    left_d   = left_q;
    idx_d    = idx_q;
    col_d    = col_q;
    brk_l_d  = brk_l_q;
    brk_t_d  = brk_t_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    hit_d    = 1'b0;
    side_d   = side_q;
    hidx_d   = hidx_q;
    case (state_q)
      IDLE: begin
        if (refr_tick_i) begin
          ball_x_d = {1'b0, ball_x_l_i};
          ball_y_d = {1'b0, ball_y_t_i};
          idx_d    = '0;
          col_d    = '0;
          brk_l_d  = FIELD_X;
          brk_t_d  = FIELD_Y;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (overlap) begin
          alive_d[idx_q] = 1'b0;
          left_d         = left_q - CW'(1);
          hidx_d         = idx_q;
          side_d         = side_c;
          hit_d          = 1'b1;
          state_d        = DONE;
        end else if (idx_q == IW'(N - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == CLW'(NUM_COLS - 1)) begin
            col_d   = '0;
            brk_l_d = FIELD_X;
            brk_t_d = brk_t_q + STEP_Y;
          end else begin
            col_d   = col_q + CLW'(1);
            brk_l_d = brk_l_q + STEP_X;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear_i) begin
      alive_d = '1;
      left_d  = CW'(N);
      state_d = IDLE;
      hit_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      alive_q  <= '1;
      left_q   <= CW'(N);
      idx_q    <= '0;
      col_q    <= '0;
      brk_l_q  <= FIELD_X;
      brk_t_q  <= FIELD_Y;
      ball_x_q <= '0;
      ball_y_q <= '0;
      hit_q    <= 1'b0;
      side_q   <= 2'd0;
      hidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      left_q   <= left_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      brk_l_q  <= brk_l_d;
      brk_t_q  <= brk_t_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      hit_q    <= hit_d;
      side_q   <= side_d;
      hidx_q   <= hidx_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign hit_o         = hit_q;
  assign hit_side_o    = side_q;
  assign hit_index_o   = hidx_q;
  assign bricks_left_o = left_q;
  assign all_cleared_o = (left_q == '0);

endmodule

// File: tb/tb_brick_field_engine.sv
// Bench for brick_field_engine: directed frames plus randomized ticks/clears,
// all checked every cycle against a frame-level model of the brick field.
module tb_brick_field_engine;

  localparam int NC  = 8;
  localparam int NR  = 6;
  localparam int BW  = 35;
  localparam int BH  = 20;
  localparam int RXL = 40;
  localparam int RYT = 30;
  localparam int BS  = 8;
  localparam int N   = NC * NR;

  logic       clk, reset;
  logic [9:0] pix_x, pix_y, ball_x, ball_y;
  logic       refr, clr;
  logic       brick_on, busy, hit, all_cleared;
  logic [1:0] hit_side;
  logic [5:0] hit_index;
  logic [5:0] bricks_left;

  brick_field_engine dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pix_x_i       (pix_x),
    .pix_y_i       (pix_y),
    .ball_x_l_i    (ball_x),
    .ball_y_t_i    (ball_y),
    .refr_tick_i   (refr),
    .clear_i       (clr),
    .brick_on_o    (brick_on),
    .busy_o        (busy),
    .hit_o         (hit),
    .hit_side_o    (hit_side),
    .hit_index_o   (hit_index),
    .bricks_left_o (bricks_left),
    .all_cleared_o (all_cleared)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  int nvec, nerr;
  bit chk_en;

  // Frame-level model: scan outcome is decided at the tick, then replayed on
  // the cycle timeline (hit at t+2+k, busy through t+2+k, or t+N on a miss).
  bit m_alive[N];
  int m_left, m_idx, m_side;
  bit m_busy, exp_hit;
  int cyc, busy_end, hit_at, pk, ps;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void scan_field(input int bx, input int by, output int k, output int s);
    int l, r, t, b, bxr, byb, dx, dy;
    k = -1;
    s = 0;
    for (int j = 0; j < N; j++) begin
      l = RXL + (j % NC) * BW;  r = l + BW - 1;
      t = RYT + (j / NC) * BH;  b = t + BH - 1;
      bxr = bx + BS - 1;        byb = by + BS - 1;
      if (k < 0 && m_alive[j] && bxr >= l && bx <= r && byb >= t && by <= b) begin
        k  = j;
        dx = ((bxr - l) < (r - bx) ? (bxr - l) : (r - bx)) + 1;
        dy = ((byb - t) < (b - by) ? (byb - t) : (b - by)) + 1;
        if (dx < dy) s = (bx + BS / 2 < l + BW / 2) ? 2 : 3;
        else         s = (by + BS / 2 < t + BH / 2) ? 0 : 1;
      end
    end
  endfunction

  function automatic int exp_brick_on(input int px, input int py);
    int col, row;
    if (px < RXL || py < RYT) return 0;
    col = (px - RXL) / BW;
    row = (py - RYT) / BH;
    if (col >= NC || row >= NR) return 0;
    return int'(m_alive[row * NC + col]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) m_alive[j] = 1'b1;
    m_left = N; m_idx = 0; m_side = 0; m_busy = 1'b0; exp_hit = 1'b0;
    cyc = 0; busy_end = 0; hit_at = -1; pk = 0; ps = 0;
  endtask

  // Called just after each active edge, with the inputs that edge sampled.
  task automatic model_step();
    bit prev_busy;
    int t, k, s;
    prev_busy = m_busy;
    cyc++;
    exp_hit = 1'b0;
    if (clr) begin
      for (int j = 0; j < N; j++) m_alive[j] = 1'b1;
      m_left = N; m_busy = 1'b0; busy_end = 0; hit_at = -1;
    end else begin
      if (!prev_busy && refr) begin
        t = cyc - 1;
        scan_field(int'(ball_x), int'(ball_y), k, s);
        if (k >= 0) begin
          hit_at = t + 2 + k; busy_end = t + 3 + k; pk = k; ps = s;
        end else begin
          hit_at = -1; busy_end = t + 1 + N;
        end
      end
      if (cyc == hit_at) begin
        m_alive[pk] = 1'b0; m_left--; m_idx = pk; m_side = ps; exp_hit = 1'b1;
      end
      m_busy = (busy_end > cyc);
    end
  endtask

  // Every-cycle comparison against the model, half a period after the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("hit", int'(hit), int'(exp_hit));
      chk("hit_index", int'(hit_index), m_idx);
      chk("hit_side", int'(hit_side), m_side);
      chk("bricks_left", int'(bricks_left), m_left);
      chk("all_cleared", int'(all_cleared), int'(m_left == 0));
      chk("brick_on", int'(brick_on), exp_brick_on(int'(pix_x), int'(pix_y)));
    end
  end

  task automatic step(input bit r, input bit c, input int bx, input int by);
    refr   = r;
    clr    = c;
    ball_x = 10'(bx);
    ball_y = 10'(by);
    pix_x  = 10'($urandom_range(20, 340));
    pix_y  = 10'($urandom_range(10, 180));
    @(posedge clk);
    model_step();
    #2;
    refr = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic wait_idle(input int retick_at, output int n, output int h);
    n = 0;
    h = 0;
    while (busy && n < 200) begin
      if (hit) h++;
      step(n == retick_at, 1'b0, $urandom_range(0, 420), $urandom_range(0, 260));
      n++;
    end
    chk("wait_idle_bound", int'(busy), 0);
  endtask

  task automatic probe(input string name, input int px, input int py, input int exp);
    pix_x = 10'(px);
    pix_y = 10'(py);
    #1;
    chk(name, int'(brick_on), exp);
  endtask

  initial begin
    int n, h;
    nvec = 0; nerr = 0; chk_en = 1'b0;
    reset = 1'b1; refr = 1'b0; clr = 1'b0;
    pix_x = '0; pix_y = '0; ball_x = '0; ball_y = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;

    chk("rst_bricks_left", int'(bricks_left), 48);
    chk("rst_all_cleared", int'(all_cleared), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_hit_side", int'(hit_side), 0);
    chk("rst_hit_index", int'(hit_index), 0);
    probe("rst_on_40_30", 40, 30, 1);
    probe("rst_on_319_149", 319, 149, 1);
    probe("rst_off_39_30", 39, 30, 0);
    probe("rst_off_320_30", 320, 30, 0);

    // Ball (36,35): brick 0 struck on its left face two cycles after the tick.
    step(1'b1, 1'b0, 36, 35);
    chk("b0_no_hit_t1", int'(hit), 0);
    step(1'b0, 1'b0, 600, 400);
    chk("b0_hit", int'(hit), 1);
    chk("b0_index", int'(hit_index), 0);
    chk("b0_side", int'(hit_side), 2);
    chk("b0_left", int'(bricks_left), 47);
    probe("b0_gone", 50, 40, 0);
    wait_idle(-1, n, h);

    // Ball (100,46): brick 1 bottom face (dx 10, dy 4), brick 9 left alive.
    step(1'b1, 1'b0, 100, 46);
    step(1'b0, 1'b0, 0, 0);
    chk("b1_no_hit_t2", int'(hit), 0);
    step(1'b0, 1'b0, 0, 0);
    chk("b1_hit", int'(hit), 1);
    chk("b1_index", int'(hit_index), 1);
    chk("b1_side", int'(hit_side), 1);
    chk("b1_left", int'(bricks_left), 46);
    probe("b9_alive", 80, 55, 1);
    wait_idle(-1, n, h);

    // Ball (70,35) straddles bricks 0 and 1: lowest index first.
    step(1'b0, 1'b1, 0, 0);
    chk("clr_left", int'(bricks_left), 48);
    step(1'b1, 1'b0, 70, 35);
    step(1'b0, 1'b0, 0, 0);
    chk("str_index0", int'(hit_index), 0);
    chk("str_side0", int'(hit_side), 3);
    wait_idle(-1, n, h);
    // Ball centre x 74 lies left of brick 1's centre x 92, and dx 3 < dy 13.
    step(1'b1, 1'b0, 70, 35);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("str_hit1", int'(hit), 1);
    chk("str_index1", int'(hit_index), 1);
    chk("str_side1", int'(hit_side), 2);
    wait_idle(-1, n, h);

    // Miss: full-length scan, re-tick mid-scan ignored.
    step(1'b1, 1'b0, 500, 400);
    wait_idle(10, n, h);
    chk("miss_busy_cycles", n, 48);
    chk("miss_hits", h, 0);

    // Clear during scan aborts it.
    step(1'b1, 1'b0, 290, 135);
    repeat (4) step(1'b0, 1'b0, 0, 0);
    chk("abort_busy_before", int'(busy), 1);
    step(1'b0, 1'b1, 0, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_hit", int'(hit), 0);
    chk("abort_left", int'(bricks_left), 48);

    // Randomized ticks and occasional clears.
    for (int i = 0; i < 700; i++) begin
      step(($urandom % 6) == 0, ($urandom % 60) == 0,
           $urandom_range(0, 420), $urandom_range(0, 260));
    end
    wait_idle(-1, n, h);

    // Destroy every brick in order, then confirm an empty field scans clean.
    step(1'b0, 1'b1, 0, 0);
    for (int j = 0; j < N; j++) begin
      step(1'b1, 1'b0, RXL + (j % NC) * BW + 13, RYT + (j / NC) * BH + 6);
      wait_idle(-1, n, h);
      chk("seq_hit", h, 1);
    end
    chk("empty_left", int'(bricks_left), 0);
    chk("empty_all_cleared", int'(all_cleared), 1);
    step(1'b1, 1'b0, 36, 35);
    wait_idle(-1, n, h);
    chk("empty_hits", h, 0);
    chk("empty_busy_cycles", n, 48);
    chk("empty_still_cleared", int'(all_cleared), 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
